// File: rtl/cla_pipe_16.sv
// cla_pipe_16 -- two-stage pipelined 16-bit carry-lookahead adder.
//
// Stage 1 registers the per-bit propagate/generate terms and carry-in.
// Stage 2 forms four 4-bit group generate/propagate terms. A second-level
// lookahead turns them into the group carries. A 4-bit lookahead inside each
// group then gives the bit carries. Sum, carry-out, signed overflow and the
// 16-bit block generate/propagate are registered from these carries.
// Valid/ready handshaking on both ends lets the pipe stall without losing
// operands.
//
// Ports:
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   a, b       16-bit operands
//   cin        carry-in
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle
//   sum        registered (a+b+cin) mod 2^16
//   cout       registered carry out of bit 15
//   overflow   registered signed overflow (carry into bit 15 ^ carry out)
//   g_o, p_o   registered 16-bit block generate / propagate
//   out_valid  result outputs are valid
//   out_ready  downstream accepts the result this cycle
module cla_pipe_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        overflow,
  output logic        g_o,
  output logic        p_o,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [15:0] s1_p;
  logic [15:0] s1_g;
  logic        s1_cin;
  logic        s1_v;

  logic        adv1;
  logic        adv2;

  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  gc;
  logic [15:0] c;
  logic        blk_g;
  logic        blk_p;

  // Generate of a 4-bit group, ignoring its carry-in.
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carries into positions 0..3 of a 4-bit group, all formed directly from
  // the group carry-in so nothing ripples bit to bit.
  function automatic logic [3:0] in_carries(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       ci);
    logic [3:0] r;
    r[0] = ci;
    r[1] = g[0] | (p[0] & ci);
    r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
           (p[2] & p[1] & p[0] & ci);
    return r;
  endfunction

  // Stage 2 may load whenever its result is absent or being taken.
  // Stage 1 may load whenever it is empty or stage 2 is moving.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1;

  // First-level group generate/propagate.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = grp_gen(s1_g[4*k +: 4], s1_p[4*k +: 4]);
      grp_p[k] = &s1_p[4*k +: 4];
    end
  end

  // The second-level lookahead uses the same equations, applied to the
  // group terms. gc[k] is the carry into group k, and gc[4] is c16.
  assign blk_g    = grp_gen(grp_g, grp_p);
  assign blk_p    = &grp_p;
  assign gc[3:0]  = in_carries(grp_g, grp_p, s1_cin);
  assign gc[4]    = blk_g | (blk_p & s1_cin);

  // Bit carries inside each group.
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = in_carries(s1_g[4*k +: 4], s1_p[4*k +: 4], gc[k]);
    end
  end

  // Stage 1 captures the bit propagate/generate terms on an input transfer.
  // An advance with no new operand only clears the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_p   <= '0;
      s1_g   <= '0;
      s1_cin <= 1'b0;
    end else if (adv1) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_p   <= a ^ b;
        s1_g   <= a & b;
        s1_cin <= cin;
      end
    end
  end

  // Stage 2 always moves the valid bit. The result data only changes for a
  // real operation, so the outputs keep their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      g_o       <= 1'b0;
      p_o       <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_v;
      if (s1_v) begin
        sum      <= s1_p ^ c;
        cout     <= gc[4];
        overflow <= c[15] ^ gc[4];
        g_o      <= blk_g;
        p_o      <= blk_p;
      end
    end
  end

endmodule
